// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//
// Producer side of the register-file write port. It accepts retiring
// instructions from the MEM stage and issues exactly one registered write
// (enable, address, data) per instruction. The write data is the ALU result,
// the link address (always written to RA_REG), or a load value taken from the
// data-memory response word. Load values are extracted as byte, half or word
// and then sign- or zero-extended. A wait counter abandons loads whose
// response never arrives.
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the FSM state. While
// in_valid is high, the MEM stage must hold in_kind, in_dst, in_result,
// in_size, in_signed and in_byte_off stable until the transfer edge.
// mem_rsp_valid has no ready: the unit samples it only in WAIT_LOAD.
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   in_valid       MEM stage presents an instruction
//   in_ready       unit can accept this cycle (IDLE or WRITE)
//   in_kind        00 ALU, 01 LOAD, 10 LINK, 11 NOWRITE
//   in_dst         destination register (ignored for LINK)
//   in_result      ALU result, or PC+8 for LINK
//   in_size        load size: 00 byte, 01 half, 10/11 word
//   in_signed      sign-extend byte/half loads
//   in_byte_off    address[1:0] of the load
//   mem_rsp_valid  load response word present
//   mem_rsp_data   aligned big-endian memory word
//   wb_we          register-file write enable
//   wb_addr        register-file write address
//   wb_data        register-file write data
//   err_timeout    sticky flag, set when a load was abandoned
//   fsm_state      current FSM state (IDLE=0, WAIT_LOAD=1, WRITE=2), debug
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int DATA_W       = 32,
    parameter int RA_REG       = 31,
    parameter int LOAD_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_dst,
    input  logic [DATA_W-1:0] in_result,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [1:0]        in_byte_off,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_timeout,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_LOAD = 2'd1;
    localparam logic [1:0] S_WRITE     = 2'd2;

    localparam logic [1:0] K_ALU     = 2'b00;
    localparam logic [1:0] K_LOAD    = 2'b01;
    localparam logic [1:0] K_LINK    = 2'b10;
    localparam logic [1:0] K_NOWRITE = 2'b11;

    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [4:0] RA_ADDR = 5'(RA_REG);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Load attributes captured at accept, used when the response arrives.
    logic [4:0] ld_dst;
    logic [1:0] ld_size;
    logic       ld_signed;
    logic [1:0] ld_off;

    logic accept;

    assign in_ready  = (state == S_IDLE) || (state == S_WRITE);
    assign accept    = in_valid && in_ready;
    assign fsm_state = state;

    // Big-endian extraction: byte offset 0 is the most significant byte.
    // Half loads use only off[1]; size 11 behaves as a word.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] w,
        input logic [1:0]  size,
        input logic        sgn,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            wb_we       <= 1'b0;
            wb_addr     <= 5'd0;
            wb_data     <= '0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
            ld_dst      <= 5'd0;
            ld_size     <= 2'b00;
            ld_signed   <= 1'b0;
            ld_off      <= 2'b00;
        end else begin
            case (state)
                S_IDLE, S_WRITE: begin
                    // The write pulse lasts one cycle unless a new
                    // ALU/LINK instruction re-arms it below.
                    wb_we <= 1'b0;
                    if (accept) begin
                        case (in_kind)
                            K_ALU: begin
                                state <= S_WRITE;
                                // Register 0 is never written; address and
                                // data keep their last values in that case.
                                if (in_dst != 5'd0) begin
                                    wb_we   <= 1'b1;
                                    wb_addr <= in_dst;
                                    wb_data <= in_result;
                                end
                            end
                            K_LINK: begin
                                state   <= S_WRITE;
                                wb_we   <= 1'b1;
                                wb_addr <= RA_ADDR;
                                wb_data <= in_result;
                            end
                            K_LOAD: begin
                                state     <= S_WAIT_LOAD;
                                wait_cnt  <= '0;
                                ld_dst    <= in_dst;
                                ld_size   <= in_size;
                                ld_signed <= in_signed;
                                ld_off    <= in_byte_off;
                            end
                            K_NOWRITE: begin
                                state <= S_WRITE;
                            end
                            default: begin
                                state <= S_WRITE;
                            end
                        endcase
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_WAIT_LOAD: begin
                    wb_we <= 1'b0;
                    // A response in the final counted cycle still wins
                    // over the timeout.
                    if (mem_rsp_valid) begin
                        state <= S_WRITE;
                        if (ld_dst != 5'd0) begin
                            wb_we   <= 1'b1;
                            wb_addr <= ld_dst;
                            wb_data <= fmt_load(mem_rsp_data, ld_size,
                                                ld_signed, ld_off);
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= S_IDLE;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    wb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_unit
//
// Directed vector table plus hand-written sequences for writeback_unit.
// Expected writes go to exp_q when an instruction is issued. The negedge
// monitor pops one entry from exp_q for each wb_we pulse and compares it.
// -----------------------------------------------------------------------------
module tb_writeback_unit;

    localparam int LOAD_TIMEOUT = 64;

    localparam logic [1:0] K_ALU     = 2'b00;
    localparam logic [1:0] K_LOAD    = 2'b01;
    localparam logic [1:0] K_LINK    = 2'b10;
    localparam logic [1:0] K_NOWRITE = 2'b11;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'b00;
    logic [4:0]  in_dst = 5'd0;
    logic [31:0] in_result = 32'd0;
    logic [1:0]  in_size = 2'b00;
    logic        in_signed = 1'b0;
    logic [1:0]  in_byte_off = 2'b00;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'd0;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_timeout;
    logic [1:0]  fsm_state;

    writeback_unit #(
        .DATA_W(32),
        .RA_REG(31),
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_kind(in_kind),
        .in_dst(in_dst),
        .in_result(in_result),
        .in_size(in_size),
        .in_signed(in_signed),
        .in_byte_off(in_byte_off),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data),
        .wb_we(wb_we),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .err_timeout(err_timeout),
        .fsm_state(fsm_state)
    );

    // scoreboard
    logic [36:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clock) begin
        if (!reset && wb_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: got addr=%0d data=0x%08h expected no write",
                         wb_addr, wb_data);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({wb_addr, wb_data} === e) passes++;
                else $display("FAIL sb_write: got addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                              wb_addr, wb_data, e[36:32], e[31:0]);
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Present one instruction and return at #1 after its accept edge.
    task automatic issue(input logic [1:0] kind, input logic [4:0] dst,
                         input logic [31:0] res, input logic [1:0] size,
                         input logic sgn, input logic [1:0] off);
        int guard;
        in_kind = kind; in_dst = dst; in_result = res;
        in_size = size; in_signed = sgn; in_byte_off = off;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (!in_ready) chk("issue_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Pulse a load response one cycle, starting dly cycles after accept.
    task automatic respond(input int dly, input logic [31:0] data);
        repeat (dly - 1) @(posedge clock);
        #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  dst;
        logic [31:0] result;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] rsp;
        int          dly;     // 0 selects a random response delay
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d;
        // kind, dst, result, size, sgn, off, rsp, dly, we, addr, data
        vecs[0]  = '{K_ALU,     5'd5,  32'h0000_1234, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b1, 5'd5,  32'h0000_1234};
        vecs[1]  = '{K_LOAD,    5'd8,  32'h0,         2'b00, 1'b1, 2'd1, 32'h12F4_5678, 2, 1'b1, 5'd8,  32'hFFFF_FFF4};
        vecs[2]  = '{K_LOAD,    5'd9,  32'h0,         2'b01, 1'b0, 2'd2, 32'h1234_8001, 0, 1'b1, 5'd9,  32'h0000_8001};
        vecs[3]  = '{K_LOAD,    5'd9,  32'h0,         2'b01, 1'b1, 2'd2, 32'h1234_8001, 0, 1'b1, 5'd9,  32'hFFFF_8001};
        vecs[4]  = '{K_LOAD,    5'd10, 32'h0,         2'b01, 1'b0, 2'd1, 32'hABCD_1234, 0, 1'b1, 5'd10, 32'h0000_ABCD};
        vecs[5]  = '{K_LOAD,    5'd11, 32'h0,         2'b00, 1'b0, 2'd3, 32'h1234_56F0, 0, 1'b1, 5'd11, 32'h0000_00F0};
        vecs[6]  = '{K_LOAD,    5'd12, 32'h0,         2'b00, 1'b1, 2'd0, 32'h7F00_0000, 0, 1'b1, 5'd12, 32'h0000_007F};
        vecs[7]  = '{K_LOAD,    5'd13, 32'h0,         2'b10, 1'b1, 2'd3, 32'hDEAD_BEEF, 0, 1'b1, 5'd13, 32'hDEAD_BEEF};
        vecs[8]  = '{K_LOAD,    5'd14, 32'h0,         2'b11, 1'b1, 2'd1, 32'h8000_0001, 1, 1'b1, 5'd14, 32'h8000_0001};
        vecs[9]  = '{K_LOAD,    5'd0,  32'h0,         2'b00, 1'b1, 2'd2, 32'h0000_8000, 0, 1'b0, 5'd14, 32'h8000_0001};
        vecs[10] = '{K_NOWRITE, 5'd6,  32'h5555_5555, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b0, 5'd14, 32'h8000_0001};
        vecs[11] = '{K_ALU,     5'd0,  32'hAAAA_AAAA, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b0, 5'd14, 32'h8000_0001};
        vecs[12] = '{K_LINK,    5'd4,  32'h0000_0100, 2'b00, 1'b0, 2'd0, 32'h0,         0, 1'b1, 5'd31, 32'h0000_0100};
        vecs[13] = '{K_LOAD,    5'd15, 32'h0,         2'b00, 1'b1, 2'd2, 32'h0000_8000, 0, 1'b1, 5'd15, 32'hFFFF_FF80};

        // reset state
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_we",    {31'd0, wb_we}, 32'd0);
        chk("rst_addr",  {27'd0, wb_addr}, 32'd0);
        chk("rst_data",  wb_data, 32'd0);
        chk("rst_err",   {31'd0, err_timeout}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_state", {30'd0, fsm_state}, 32'd0);

        // table-driven vectors
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].exp_we) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
            issue(vecs[i].kind, vecs[i].dst, vecs[i].result,
                  vecs[i].size, vecs[i].sgn, vecs[i].off);
            if (vecs[i].kind == K_LOAD) begin
                chk($sformatf("v%0d_wait_ready", i), {31'd0, in_ready}, 32'd0);
                d = (vecs[i].dly == 0) ? int'($urandom_range(1, 6)) : vecs[i].dly;
                respond(d, vecs[i].rsp);
            end
            chk($sformatf("v%0d_we", i),   {31'd0, wb_we}, {31'd0, vecs[i].exp_we});
            chk($sformatf("v%0d_addr", i), {27'd0, wb_addr}, {27'd0, vecs[i].exp_addr});
            chk($sformatf("v%0d_data", i), wb_data, vecs[i].exp_data);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        // back-to-back ALU, LINK, ALU to r0 with in_valid held
        @(posedge clock); #1;
        in_valid = 1'b1; in_kind = K_ALU; in_dst = 5'd3; in_result = 32'h0000_000A;
        exp_q.push_back({5'd3, 32'h0000_000A});
        chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        chk("b2b_w0", {wb_we, 26'd0, wb_addr}, {1'b1, 26'd0, 5'd3});
        in_kind = K_LINK; in_dst = 5'd7; in_result = 32'h0040_0010;
        exp_q.push_back({5'd31, 32'h0040_0010});
        chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        chk("b2b_w1", {wb_we, 26'd0, wb_addr}, {1'b1, 26'd0, 5'd31});
        chk("b2b_d1", wb_data, 32'h0040_0010);
        in_kind = K_ALU; in_dst = 5'd0; in_result = 32'h0000_00FF;
        chk("b2b_ready2", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("b2b_w2_we", {31'd0, wb_we}, 32'd0);

        // response in the final counted cycle beats the timeout
        @(posedge clock); #1;
        exp_q.push_back({5'd16, 32'h0000_0055});
        issue(K_LOAD, 5'd16, 32'h0, 2'b00, 1'b0, 2'd3);
        respond(LOAD_TIMEOUT, 32'h1122_3355);
        chk("last_rsp_we",  {31'd0, wb_we}, 32'd1);
        chk("last_rsp_err", {31'd0, err_timeout}, 32'd0);

        // load abandoned after LOAD_TIMEOUT waiting cycles
        @(posedge clock); #1;
        issue(K_LOAD, 5'd17, 32'h0, 2'b10, 1'b0, 2'd0);
        repeat (LOAD_TIMEOUT - 1) @(posedge clock);
        #1;
        chk("to_pre_ready", {31'd0, in_ready}, 32'd0);
        chk("to_pre_err",   {31'd0, err_timeout}, 32'd0);
        @(posedge clock); #1;
        chk("to_err",   {31'd0, err_timeout}, 32'd1);
        chk("to_ready", {31'd0, in_ready}, 32'd1);
        chk("to_we",    {31'd0, wb_we}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        chk("late_rsp_state", {30'd0, fsm_state}, 32'd0);
        chk("late_rsp_we",    {31'd0, wb_we}, 32'd0);
        chk("late_rsp_err",   {31'd0, err_timeout}, 32'd1);
        do_reset();
        chk("to_rst_err", {31'd0, err_timeout}, 32'd0);

        // reset during WAIT_LOAD drops the load
        exp_q.push_back({5'd18, 32'h1357_9BDF});
        issue(K_ALU, 5'd18, 32'h1357_9BDF, 2'b00, 1'b0, 2'd0);
        issue(K_LOAD, 5'd20, 32'h0, 2'b10, 1'b0, 2'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("mid_state", {30'd0, fsm_state}, 32'd1);
        do_reset();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h9999_9999;
        @(posedge clock); #1;
        mem_rsp_valid = 1'b0;
        @(posedge clock); #1;
        chk("mid_rst_we",    {31'd0, wb_we}, 32'd0);
        chk("mid_rst_addr",  {27'd0, wb_addr}, 32'd0);
        chk("mid_rst_data",  wb_data, 32'd0);
        chk("mid_rst_err",   {31'd0, err_timeout}, 32'd0);
        chk("mid_rst_state", {30'd0, fsm_state}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);

        repeat (3) @(posedge clock);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Producer side of the register-file write port. Accepts retiring instructions from the MEM stage over a valid/ready handshake and selects the write-back value:
- ALU result, passed through;
- link address, forced to the return-address register;
- load data from the data-memory response, with byte/half extraction and sign/zero extension.

It drives exactly one registered write (enable, address, data) per instruction into the register file. A bounded wait covers slow load responses.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
RA_REG, 31, destination register forced for LINK kind.
LOAD_TIMEOUT, 64, maximum number of cycles spent in WAIT_LOAD before the load is abandoned.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
in_valid  in  1  MEM stage presents an instruction.
in_ready  out  1  unit can accept this cycle.
in_kind  in  2  00 ALU, 01 LOAD, 10 LINK, 11 NOWRITE.
in_dst  in  5  destination register; ignored for LINK.
in_result  in  32  ALU result, or PC+8 for LINK.
in_size  in  2  load size: 00 byte, 01 half, 10 word.
in_signed  in  1  sign-extend byte/half loads.
in_byte_off  in  2  address[1:0] of the load.
mem_rsp_valid  in  1  load response word present.
mem_rsp_data  in  32  aligned memory word; byte offset 0 is the most significant byte (big-endian).
wb_we  out  1  register-file write enable.
wb_addr  out  5  register-file write address.
wb_data  out  32  register-file write data.
err_timeout  out  1  sticky; set when a load was abandoned.

Behaviour:
- States: IDLE, WAIT_LOAD, WRITE.
- in_ready = (state==IDLE || state==WRITE). An accept is the cycle where in_valid && in_ready.
- Reset (synchronous, any state, including mid-load): state=IDLE, wb_we=0, wb_addr=0, wb_data=0, err_timeout=0, wait counter=0. A pending load is dropped and its later response is ignored.
- Accept of ALU at cycle N: captures addr=in_dst, data=in_result, then goes to WRITE. wb_we=1 during cycle N+1.
- Accept of LINK at cycle N: same as ALU, but addr=RA_REG regardless of in_dst.
- Accept of NOWRITE: goes to WRITE with the write enable suppressed (wb_we=0). This still consumes one slot.
- in_dst==0 on ALU or LOAD: full flow, but wb_we stays 0 in the WRITE cycle. Register 0 is never written.
- Accept of LOAD at cycle N:
  - captures dst, size, signed and byte_off, then goes to WAIT_LOAD with the counter cleared;
  - mem_rsp_valid is sampled only in WAIT_LOAD (earliest at cycle N+1);
  - response at cycle M: formats the data, goes to WRITE, wb_we=1 in cycle M+1.
- Load formatting:
  - word: data unchanged; byte_off is ignored.
  - half: byte_off[1]=0 selects the upper 16 bits, 1 the lower 16 bits; byte_off[0] is ignored.
  - byte: byte_off 0..3 selects from most to least significant byte.
  - Extension: sign-extend if in_signed, otherwise zero-extend.
  - in_size=11 is treated as word.
- Timeout: the counter increments each WAIT_LOAD cycle without a response. When it reaches LOAD_TIMEOUT-1 with no response, the next edge sets err_timeout, goes to IDLE, and performs no write. A response arriving in that same final cycle wins: the write happens and there is no error.
- mem_rsp_valid in IDLE or WRITE is ignored and has no side effect.
- WRITE lasts exactly one cycle. If a new accept occurs in it, the next state follows that instruction's kind; otherwise the next state is IDLE.
- ALU/LINK throughput is one per cycle when in_valid is held high.
- wb_addr/wb_data hold their last values when wb_we=0. Only wb_we is qualified.
- in_ready is low throughout WAIT_LOAD.
- err_timeout is cleared only by reset.

Test Plan:
1. Reset, then ALU dst=5, result=0x0000_1234 accepted at cycle 1 -> cycle 2 has wb_we=1, wb_addr=5, wb_data=0x1234; cycle 3 has wb_we=0.
2. Back-to-back ALU dst=3 (0xA), LINK dst=7 (0x0040_0010), ALU dst=0 (0xFF) with in_valid held -> writes on 3 consecutive cycles are (3,0xA) then (31,0x0040_0010); the third cycle has wb_we=0; in_ready is high every cycle.
3. LOAD byte, signed, off=1, dst=8; response 0x12F4_5678 two cycles later -> one cycle after the response, wb_addr=8, wb_data=0xFFFF_FFF4; in_ready is low while waiting.
4. LOAD half, unsigned, off=2, dst=9; response 0x1234_8001 -> wb_data=0x0000_8001. Repeat with signed -> 0xFFFF_8001.
5. LOAD with no response for LOAD_TIMEOUT cycles -> no wb_we, err_timeout=1, in_ready returns high. A late mem_rsp_valid is then ignored. Reset clears err_timeout.
6. Assert reset during WAIT_LOAD, then deliver a response -> no write occurs; all outputs are 0 and the state is IDLE.
